// File: rtl/spi_pkg.sv
// Shared SPI mode-0 definitions: FSM state encoding and idle line levels.
package spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_SETUP = ST_SETUP,
    S_HIGH  = ST_HIGH,
    S_LOW   = ST_LOW,
    S_HOLD  = ST_HOLD,
    S_DONE  = ST_DONE
  } state_e;

  localparam logic SCK_IDLE  = 1'b0;
  localparam logic SS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b1;

  // Slave select is asserted for every state between request accept and response.
  function automatic logic is_active(input state_e s);
    return (s == S_SETUP) || (s == S_HIGH) || (s == S_LOW) || (s == S_HOLD);
  endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period timer: tick pulses on count CLK_DIV-1 and the count restarts at 0.
module spi_clkdiv #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one request in, MSB-first full-duplex shift of n bits, one response out.
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [WIDTH-1:0]             req_data,
  input  logic [$clog2(WIDTH+1)-1:0]   req_len,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WIDTH-1:0]             rsp_data,
  output logic                         sck,
  output logic                         ss,
  output logic                         mosi,
  input  logic                         miso
);

  localparam int LW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [LW-1:0]    bits_q, bits_d;
  logic [LW-1:0]    n_eff;
  logic             tail_q, tail_d;
  logic             sck_q, sck_d;
  logic             ss_q, ss_d;
  logic             mosi_q, mosi_d;
  logic             div_clear;
  logic             tick;
  int               shamt;

  spi_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clock (clock),
    .reset (reset),
    .clear (div_clear),
    .tick  (tick)
  );

  assign div_clear = (state_q == S_IDLE) || (state_q == S_DONE);

  always_comb begin
    n_eff = req_len;
    if ((req_len == '0) || (req_len > LW'(WIDTH))) n_eff = LW'(WIDTH);
    shamt = WIDTH - int'(n_eff);
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bits_d  = bits_q;
    tail_d  = tail_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          tx_d    = req_data << shamt;
          rx_d    = '0;
          bits_d  = n_eff;
          tail_d  = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP, S_LOW: begin
        if (tick) begin
          rx_d    = {rx_q[WIDTH-2:0], miso};
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (tick) begin
          bits_d = bits_q - LW'(1);
          if (bits_q == LW'(1)) begin
            state_d = S_HOLD;
          end else begin
            tx_d    = tx_q << 1;
            state_d = S_LOW;
          end
        end
      end
      // HOLD covers the trailing sck-low half period, then the ss hold half period.
      S_HOLD: begin
        if (tick) begin
          if (tail_q) state_d = S_DONE;
          else        tail_d  = 1'b1;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    sck_d  = (state_d == S_HIGH) ? ~SCK_IDLE : SCK_IDLE;
    ss_d   = is_active(state_d) ? ~SS_IDLE : SS_IDLE;
    mosi_d = is_active(state_d) ? tx_d[WIDTH-1] : MOSI_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      bits_q  <= '0;
      tail_q  <= 1'b0;
      sck_q   <= SCK_IDLE;
      ss_q    <= SS_IDLE;
      mosi_q  <= MOSI_IDLE;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bits_q  <= bits_d;
      tail_q  <= tail_d;
      sck_q   <= sck_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = rx_q;
  assign sck       = sck_q;
  assign ss        = ss_q;
  assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master with a behavioural SPI slave and a reference model.
module tb_spi_master;

  localparam int W  = 16;
  localparam int CD = 2;
  localparam int LW = $clog2(W + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_data = '0;
  logic [LW-1:0] req_len = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [W-1:0]  rsp_data;
  logic          sck, ss, mosi, miso;

  logic          f_req_valid = 1'b0;
  logic          f_req_ready;
  logic [W-1:0]  f_req_data = '0;
  logic [LW-1:0] f_req_len = '0;
  logic          f_rsp_valid;
  logic          f_rsp_ready = 1'b1;
  logic [W-1:0]  f_rsp_data;
  logic          f_sck, f_ss, f_mosi;
  logic          f_miso = 1'b1;

  always #5 clock = ~clock;

  spi_master #(.WIDTH(W), .CLK_DIV(CD)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  spi_master #(.WIDTH(W), .CLK_DIV(1)) dut_fast (
    .clock(clock), .reset(reset),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_data(f_req_data), .req_len(f_req_len),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data),
    .sck(f_sck), .ss(f_ss), .mosi(f_mosi), .miso(f_miso)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  int         miso_mode = 1;      // 0 loopback, 1 constant one, 2 shift out a word, 3 bit-reverse
  logic [W-1:0] slave_word = '0;
  int         slave_n = W;
  int         rise_total = 0, fall_total = 0;
  int         rise_base = 0, fall_base = 0;
  logic [7:0] cap = '0;

  always @(negedge ss) begin
    rise_base = rise_total;
    fall_base = fall_total;
  end
  always @(negedge sck) fall_total = fall_total + 1;
  always @(posedge sck) begin
    if (rise_total - rise_base < 8) cap = {cap[6:0], mosi};
    rise_total = rise_total + 1;
  end

  function automatic logic slave_bit(input int mode, input logic m, input int idx,
                                     input logic [W-1:0] sw, input int n, input logic [7:0] c);
    case (mode)
      0: return m;
      1: return 1'b1;
      2: return (idx >= 0 && idx < n) ? sw[n-1-idx] : 1'b0;
      default: return (idx >= 8 && idx < 16) ? c[idx-8] : 1'b0;
    endcase
  endfunction

  assign miso = slave_bit(miso_mode, mosi, fall_total - fall_base, slave_word, slave_n, cap);

  // ---------------- reference model ----------------
  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [W-1:0] ref_rsp(input logic [W-1:0] d, input int n, input int mode,
                                           input logic [W-1:0] sw);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    case (mode)
      0: return W'(32'(d) & mask);
      1: return W'(mask);
      2: return W'(32'(sw) & mask);
      default: return {8'h00, bitrev8(d[15:8])};
    endcase
  endfunction

  typedef struct {
    logic [W-1:0] data;
    int           lat;
    int           pulses;
  } exp_t;

  exp_t sb[$];
  int   accept_cyc = 0;
  int   pulse_base = 0;

  // ---------------- monitor ----------------
  logic rv_prev = 1'b0;
  logic mosi_prev = 1'b1;
  int   first_cyc = 0;

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (rsp_valid && !rv_prev) first_cyc = cyc + 1;
      if (rsp_valid && rsp_ready) begin
        check("sb_pending", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rsp_data", 64'(rsp_data), 64'(e.data));
          check("latency", 64'(first_cyc - accept_cyc), 64'(e.lat));
          check("sck_pulses", 64'(rise_total - pulse_base), 64'(e.pulses));
        end
      end
      if (mosi !== mosi_prev) check("mosi_moves_with_sck_low", 64'(sck), 64'd0);
    end
    rv_prev   = rsp_valid;
    mosi_prev = mosi;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [W-1:0] d, input logic [LW-1:0] len, input int mode,
                       input logic [W-1:0] sw, input bit push);
    int   n;
    exp_t e;
    int   k;
    n = (len == 0 || int'(len) > W) ? W : int'(len);
    miso_mode  = mode;
    slave_word = sw;
    slave_n    = n;
    if (push) begin
      e.data   = ref_rsp(d, n, mode, sw);
      e.lat    = CD * (2 * n + 2) + 1;
      e.pulses = n;
      sb.push_back(e);
    end
    @(negedge clock);
    req_valid = 1'b1;
    req_data  = d;
    req_len   = len;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (k >= 200) check("req_ready_timeout", 64'(req_ready), 64'd1);
    accept_cyc = cyc + 1;
    pulse_base = rise_total;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 2000) begin
      @(negedge clock);
      k++;
    end
    check("txn_completes", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    logic [W-1:0] held;
    int           k, rv_seen, hi_cnt, lat;

    repeat (2) @(negedge clock);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_ss", 64'(ss), 64'd1);
    check("reset_sck", 64'(sck), 64'd0);
    check("reset_mosi", 64'(mosi), 64'd1);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    reset = 1'b0;

    issue(16'h00A5, 5'd8, 0, '0, 1'b1);        // loopback
    wait_done();
    issue(16'h1234, 5'd0, 1, '0, 1'b1);        // len 0 -> full width, miso high
    wait_done();
    issue(16'h0100, 5'd16, 3, '0, 1'b1);       // bit-reverse slave
    wait_done();
    issue(16'h0001, 5'd1, 2, 16'h0001, 1'b1);  // single bit
    wait_done();
    issue(16'hFFFF, 5'd20, 2, 16'h8001, 1'b1); // len above WIDTH
    wait_done();

    for (int i = 0; i < 24; i++) begin
      issue(W'($urandom), LW'($urandom_range(0, 20)), int'($urandom_range(0, 2)), W'($urandom), 1'b1);
      wait_done();
    end

    // response held off: outputs stable, new requests ignored
    rsp_ready = 1'b0;
    issue(16'h5A3C, 5'd12, 2, 16'hBEEF, 1'b1);
    k = 0;
    while (!rsp_valid && k < 2000) begin
      @(negedge clock);
      k++;
    end
    check("hold_rsp_arrives", 64'(rsp_valid), 64'd1);
    held = rsp_data;
    for (int i = 0; i < 10; i++) begin
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rsp_data", 64'(rsp_data), 64'(held));
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_ss", 64'(ss), 64'd1);
      req_valid = 1'b1;
      req_data  = 16'hFFFF;
      req_len   = 5'd4;
      @(negedge clock);
    end
    req_valid = 1'b0;
    @(posedge clock);
    #1 rsp_ready = 1'b1;
    wait_done();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("after_hold_idle_ss", 64'(ss), 64'd1);
    end

    // reset during the third HIGH phase
    issue(16'hC3C3, 5'd8, 1, '0, 1'b0);
    k = 0;
    while ((rise_total - pulse_base) < 3 && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("abort_reached_third_high", 64'(sck), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_ss", 64'(ss), 64'd1);
    check("abort_sck", 64'(sck), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (rsp_valid) rv_seen++;
    end
    check("abort_no_rsp", 64'(rv_seen), 64'd0);

    issue(16'h3C96, 5'd10, 2, 16'h02AA, 1'b1);
    wait_done();

    // CLK_DIV = 1, single bit
    @(negedge clock);
    f_req_valid = 1'b1;
    f_req_data  = 16'h0001;
    f_req_len   = 5'd1;
    lat = -1;
    hi_cnt = 0;
    accept_cyc = cyc + 1;
    for (int i = 0; i < 50 && lat < 0; i++) begin
      @(negedge clock);
      f_req_valid = 1'b0;
      if (f_sck) hi_cnt++;
      if (f_rsp_valid) begin
        lat = cyc + 1 - accept_cyc;
        check("fast_rsp_data", 64'(f_rsp_data), 64'd1);
      end
    end
    check("fast_latency", 64'(lat), 64'd5);
    check("fast_sck_high_cycles", 64'(hi_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
